// File: rtl/mul_float_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs float multiplier; MUL_FLOAT_ARBITER_STATS_EN adds op/busy counters.
// Latency: req_ready -> core_ap_start +1 cycle, core_ap_done -> rsp_valid +1 cycle.
// Backpressure: one transaction in flight; result held in RESP until rsp_ready, no grants meanwhile.
module mul_float_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_a,
    input  logic [NREQ*DATA_W-1:0]    req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      core_ap_start,
    input  logic                      core_ap_ready,
    input  logic                      core_ap_done,
    output logic [DATA_W-1:0]         core_a,
    output logic [DATA_W-1:0]         core_b,
    input  logic [DATA_W-1:0]         core_ap_return
`ifdef MUL_FLOAT_ARBITER_STATS_EN
    ,
    output logic [31:0]               stat_ops,
    output logic [31:0]               stat_busy
`endif
);
    localparam int ID_W = $clog2(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_grant;
    logic              w_any;
    logic              w_capture;
    int                w_idx;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_data;

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_any) w_state_nxt = S_START;
            S_START:     if (core_ap_ready) w_state_nxt = core_ap_done ? S_RESP : S_WAIT_DONE;
            S_WAIT_DONE: if (core_ap_done) w_state_nxt = S_RESP;
            S_RESP:      if (rsp_ready) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is sampled high.
    always_comb begin
        req_ready     = '0;
        core_ap_start = 1'b0;
        rsp_valid     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  if (w_any) req_ready[w_grant] = 1'b1;
                S_START: core_ap_start = 1'b1;
                S_RESP:  rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_capture = ((r_state == S_START) && core_ap_ready && core_ap_done) ||
                       ((r_state == S_WAIT_DONE) && core_ap_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_a      <= req_a[int'(w_grant)*DATA_W +: DATA_W];
                r_b      <= req_b[int'(w_grant)*DATA_W +: DATA_W];
                r_id     <= w_grant;
                r_rr_ptr <= (w_grant == LAST_ID) ? '0 : w_grant + 1'b1;
            end
            if (w_capture) begin
                r_data <= core_ap_return;
            end
        end
    end

    assign core_a   = reset ? '0 : r_a;
    assign core_b   = reset ? '0 : r_b;
    assign rsp_data = reset ? '0 : r_data;
    assign rsp_id   = reset ? '0 : r_id;

`ifdef MUL_FLOAT_ARBITER_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_ops  <= '0;
            r_stat_busy <= '0;
        end else begin
            if ((r_state == S_RESP) && rsp_ready && (r_stat_ops != 32'hFFFF_FFFF)) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if ((r_state != S_IDLE) && (r_stat_busy != 32'hFFFF_FFFF)) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
        end
    end

    assign stat_ops  = reset ? '0 : r_stat_ops;
    assign stat_busy = reset ? '0 : r_stat_busy;
`endif

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Scoreboard bench for mul_float_arbiter with a latency-programmable ap_ctrl_hs multiplier model.
module tb_mul_float_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [DW-1:0]   rsp_data;
    logic            rsp_id;
    logic            core_ap_start;
    logic            core_ap_ready = 1'b0;
    logic            core_ap_done  = 1'b0;
    logic [DW-1:0]   core_a;
    logic [DW-1:0]   core_b;
    logic [DW-1:0]   core_ap_return = '0;
`ifdef MUL_FLOAT_ARBITER_STATS_EN
    logic [31:0]     stat_ops;
    logic [31:0]     stat_busy;
`endif

    mul_float_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done),
        .core_a(core_a), .core_b(core_b), .core_ap_return(core_ap_return)
`ifdef MUL_FLOAT_ARBITER_STATS_EN
        , .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct packed { logic [31:0] d; logic id; } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    logic glog[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int start_cycles = 0, rspv_cycles = 0;
    int grant_cyc = 0, start_rise = 0, done_cyc = 0, rspv_rise = 0;
    int busy_model = 0;
    bit waiting = 0, prev_start = 0, prev_rspv = 0;
    bit acc0 = 0, acc1 = 0;

    // Hand-computed IEEE-754 single products: {a, b, a*b}
    function automatic logic [95:0] vec(input int i);
        case (i)
            0: return {32'h3F800000, 32'h40000000, 32'h40000000}; // 1.0 * 2.0
            1: return {32'h40000000, 32'h40400000, 32'h40C00000}; // 2.0 * 3.0
            2: return {32'h3FC00000, 32'h3FC00000, 32'h40100000}; // 1.5 * 1.5
            3: return {32'hC0000000, 32'h3F000000, 32'hBF800000}; // -2.0 * 0.5
            4: return {32'h40800000, 32'h3E800000, 32'h3F800000}; // 4.0 * 0.25
            default: return {32'h40400000, 32'h40400000, 32'h41100000}; // 3.0 * 3.0
        endcase
    endfunction

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        logic [95:0] v;
        for (int i = 0; i < 6; i++) begin
            v = vec(i);
            if (v[95:64] == a && v[63:32] == b) return v[31:0];
        end
        return 32'hDEADBEEF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Multiplier model: accepts start immediately, done after lat cycles (lat 0 = same cycle).
    int lat = 3;
    bit busy = 0;
    int cnt = 0;
    logic [31:0] res;
    always @(posedge clock) begin
        #1;
        core_ap_ready = 1'b0;
        core_ap_done  = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                core_ap_done = 1'b1;
                core_ap_return = res;
                busy = 0;
            end
        end else if (core_ap_start) begin
            core_ap_ready = 1'b1;
            if (lat == 0) begin
                core_ap_done = 1'b1;
                core_ap_return = prod(core_a, core_b);
            end else begin
                busy = 1;
                cnt = lat;
                res = prod(core_a, core_b);
            end
        end
    end

    // Requester drivers: present queue heads, pop on observed accept.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req_a[31:0] = q0[0].a; req_b[31:0] = q0[0].b;
        end else req_valid[0] = 1'b0;
        if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req_a[63:32] = q1[0].a; req_b[63:32] = q1[0].b;
        end else req_valid[1] = 1'b0;
    end

    // Monitor: scoreboard pop on response handshake plus timing bookkeeping.
    exp_t e;
    always @(negedge clock) begin
        acc0 = req_ready[0];
        acc1 = req_ready[1];
        if (reset) begin
            waiting = 0;
            busy_model = 0;
        end else begin
            if (core_ap_start || rsp_valid || waiting) busy_model++;
            if (waiting && core_ap_done) waiting = 0;
            if (core_ap_start && core_ap_ready && !core_ap_done) waiting = 1;
            if (|req_ready) begin
                grant_cyc = cyc;
                glog.push_back(req_ready[1]);
            end
            if (core_ap_start) begin
                start_cycles++;
                if (!prev_start) start_rise = cyc;
            end
            if (core_ap_done) done_cyc = cyc;
            if (rsp_valid) begin
                rspv_cycles++;
                if (!prev_rspv) rspv_rise = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("rsp_unexpected", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.d);
                    chk("rsp_id", rsp_id, e.id);
                end
            end
        end
        prev_start = core_ap_start;
        prev_rspv  = rsp_valid;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input int r, input int v);
        logic [95:0] t;
        t = vec(v);
        if (r == 0) q0.push_back('{a: t[95:64], b: t[63:32]});
        else        q1.push_back('{a: t[95:64], b: t[63:32]});
        sb.push_back('{d: t[31:0], id: r[0]});
    endtask

    task automatic pulse_reset();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !rsp_valid && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("drain_done", ok, 1);
    endtask

    task automatic wait_start(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (core_ap_start) begin
                ok = 1;
                break;
            end
        end
        chk("start_seen", ok, 1);
    endtask

    int sc0, rv0, rst_cyc;
    initial begin
        // Reset state, with a request already pending
        issue(0, 0);
        tick(); tick();
        @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ap_start", core_ap_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_b", core_b, 0);
        sc0 = start_cycles;
        tick(); reset = 1'b0;

        // Single transaction, latency 3
        wait_drain(50);
        chk("t1_start_cycles", start_cycles - sc0, 1);
        chk("t1_grant_to_start", start_rise - grant_cyc, 1);
        chk("t1_done_to_rsp", rspv_rise - done_cyc, 1);

        // Simultaneous requests after reset alternate 0,1,0,1
        pulse_reset();
        glog.delete();
        issue(0, 1); issue(1, 2); issue(0, 3); issue(1, 4);
        wait_drain(200);
        chk("alt_count", glog.size(), 4);
        if (glog.size() == 4) chk("alt_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);

        // Response stall with a competing request pending
        tick(); rsp_ready = 1'b0;
        issue(0, 5); issue(1, 1);
        begin
            bit seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (rsp_valid) begin seen = 1; break; end
            end
            chk("stall_seen", seen, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_hold", {rsp_valid, rsp_data, rsp_id, req_ready, core_ap_start},
                {1'b1, 32'h41100000, 1'b0, 2'b00, 1'b0});
        end
        tick(); rsp_ready = 1'b1;
        wait_drain(100);

        // Requester 1 withdraws before being granted
        lat = 4;
        glog.delete();
        tick();
        issue(0, 2);
        q1.push_back('{a: 32'h40800000, b: 32'h3E800000});
        wait_start(20);
        tick(); q1.delete();
        wait_drain(50);
        repeat (5) @(negedge clock);
        chk("withdraw_grants", glog.size(), 1);

        // Core ready+done in the start cycle
        lat = 0;
        sc0 = start_cycles;
        tick(); issue(1, 3);
        wait_drain(50);
        chk("lat0_start_cycles", start_cycles - sc0, 1);
        chk("lat0_start_to_rsp", rspv_rise - start_rise, 1);

        // Reset while waiting for done; late done must be ignored
        lat = 8;
        tick(); issue(0, 4);
        wait_start(20);
        repeat (2) @(negedge clock);
        tick(); reset = 1'b1;
        sb.delete();
        tick(); reset = 1'b0;
        rst_cyc = cyc;
        rv0 = rspv_cycles;
        begin
            bit ok = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (!busy) begin ok = 1; break; end
            end
            chk("late_done_drained", ok, 1);
        end
        repeat (3) @(negedge clock);
        chk("late_done_after_reset", done_cyc > rst_cyc, 1);
        chk("late_done_ignored", rspv_cycles - rv0, 0);
        lat = 3;
        tick(); issue(1, 5);
        wait_drain(50);

`ifdef MUL_FLOAT_ARBITER_STATS_EN
        // Statistics over 4 back-to-back transactions
        pulse_reset();
        issue(0, 0); issue(1, 1); issue(0, 2); issue(1, 3);
        wait_drain(200);
        repeat (2) @(negedge clock);
        chk("stat_ops", stat_ops, 4);
        chk("stat_busy", stat_busy, busy_model);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/mul_float_arbiter.md
MUL_FLOAT_ARBITER -- requirements
Module: mul_float_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_W, default 32, operand/result width (IEEE-754 single).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand pair valid.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot accept pulse.
REQ-007 SHALL have port req_a / req_b  input  NREQ*DATA_W each  packed operands, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_ready  input  1  result consumer ready.
REQ-010 SHALL have port rsp_data  output  DATA_W  product.
REQ-011 SHALL have port rsp_id  output  clog2(NREQ)  requester index of rsp_data.
REQ-012 SHALL have ports core_ap_start (out 1), core_ap_ready (in 1), core_ap_done (in 1), core_a / core_b (out DATA_W), core_ap_return (in DATA_W) to one ap_ctrl_hs mul_float_top core; core ap_continue tied 1 outside this block.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT_DONE, RESP.
REQ-014 IDLE: if any req_valid, grant round-robin starting at pointer rr_ptr; assert req_ready[g] for exactly that cycle, register req_a/req_b[g] and g, go START next cycle.
REQ-015 rr_ptr SHALL become (g+1) mod NREQ on each grant; reset value 0.
REQ-016 START: core_ap_start=1, core_a/core_b driven from registers and stable; hold until core_ap_ready=1.
REQ-017 START with core_ap_ready=1 and core_ap_done=1 same cycle: capture core_ap_return, go RESP.
REQ-018 START with core_ap_ready=1, core_ap_done=0: go WAIT_DONE; core_ap_start SHALL deassert next cycle.
REQ-019 WAIT_DONE: core_ap_start=0; on core_ap_done=1 capture core_ap_return into rsp_data, go RESP.
REQ-020 RESP: rsp_valid=1, rsp_data/rsp_id stable; on rsp_ready=1 go IDLE; no req_ready and no core_ap_start while in RESP.
REQ-021 Minimum latency req_ready pulse (cycle T) -> core_ap_start (T+1); core_ap_done (cycle D) -> rsp_valid (D+1).
REQ-022 At most one transaction outstanding in the core at any time.
REQ-023 req_valid deasserting while not granted SHALL be allowed; no state retained for ungranted requesters.
REQ-024 core_ap_done asserted outside START/WAIT_DONE SHALL be ignored.

Reset
REQ-025 reset SHALL force state IDLE, rr_ptr=0, req_ready=0, core_ap_start=0, rsp_valid=0, rsp_data=0, rsp_id=0, core_a=core_b=0.
REQ-026 reset mid-transaction SHALL abandon it; the in-flight result SHALL never be presented.
REQ-027 Outputs SHALL hold reset values in the cycle reset is sampled high and take FSM values from the first cycle after it is low.

Configuration
REQ-028 Macro MUL_FLOAT_ARBITER_STATS_EN defined: add outputs stat_ops (32, count of completed RESP handshakes) and stat_busy (32, count of cycles state != IDLE), both saturating at 0xFFFFFFFF, cleared by reset.
REQ-029 Macro undefined: stat_ops/stat_busy ports and counters absent; all other behaviour identical.

Verification
REQ-030 Req0 a=0x3F800000, b=0x40000000, core latency 3 -> one ap_start, rsp_data=0x40000000, rsp_id=0.
REQ-031 Req0 and req1 valid same cycle after reset -> req0 granted first, req1 next; with both held, grants alternate 0,1,0,1.
REQ-032 rsp_ready low 5 cycles in RESP -> rsp_valid/data/id stable, req_ready=0, core_ap_start=0 throughout.
REQ-033 Core model asserts ap_ready and ap_done same cycle as start -> rsp_valid next cycle, no WAIT_DONE visit, single ap_start cycle.
REQ-034 reset pulsed during WAIT_DONE, then late core_ap_done -> no rsp_valid; next request processed normally, rsp_id correct.
REQ-035 With MUL_FLOAT_ARBITER_STATS_EN, 4 back-to-back transactions of latency 3 -> stat_ops=4, stat_busy equals simulated non-IDLE cycle count.
